// File: rtl/jpeg_pkg.sv
// Shared JPEG decoder constants and the pixel-receiver FSM encoding.
package jpeg_pkg;
  localparam int MCU_DIM_411 = 16;
  localparam int MCU_DIM_444 = 8;
  localparam int MCU_PIX_411 = 256;
  localparam int MCU_PIX_444 = 64;
  localparam int MCU_CNT_W   = 13;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } rx_state_t;
endpackage

// File: rtl/jpeg_sync_fifo.sv
// Single-clock FIFO, first-word-fall-through: dout shows the head entry whenever !empty.
module jpeg_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop & ~empty;
  // a pop on a full FIFO frees the head slot, so the same-cycle push may reuse it
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_q];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/jpeg_pix_rx.sv
// MCU-ordered pixel stream to raster framebuffer writes; address built incrementally.
module jpeg_pix_rx
  import jpeg_pkg::*;
#(
  parameter int ADDR_W     = 22,
  parameter int FIFO_DEPTH = 4
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [12:0]       cfg_mcu_w,
  input  logic              bo_we,
  input  logic              bo_begin,
  input  logic              bo_end,
  input  logic [31:0]       bo_data,
  input  logic              bo_type,
  output logic              bi_next,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [23:0]       fb_data,
  input  logic              fb_ready,
  output logic              frame_done,
  output logic              err_sync
);
  localparam int FW = ADDR_W + 24;

  rx_state_t st_q, st_d;
  logic      rdy_q, acc, take, done_d, err_d;
  logic      full, empty, push, pop;
  logic      unused_bits;

  // latched frame config and walk counters
  logic                 type_q;
  logic [MCU_CNT_W-1:0] mcu_w_q, x_q, y_q;
  logic [7:0]           pix_q;
  logic [ADDR_W-1:0]    stride_q, base_q, rowst_q, roff_q;

  // effective values for the current beat (a begin beat restarts at MCU (0,0))
  logic                 e_type;
  logic [MCU_CNT_W-1:0] e_w, e_x, e_y;
  logic [7:0]           e_pix;
  logic [ADDR_W-1:0]    e_stride, e_base, e_rowst, e_roff;

  logic                 last_col, last_pix, last_x;
  logic [ADDR_W-1:0]    dim, col, dim_stride, addr;
  logic [MCU_CNT_W-1:0] x_n, y_n;
  logic [7:0]           pix_n;
  logic [ADDR_W-1:0]    base_n, rowst_n, roff_n;

  logic                 s_vld;
  logic [ADDR_W-1:0]    s_addr;
  logic [23:0]          s_data;
  logic [FW-1:0]        f_dout;

  assign unused_bits = ^bo_data[7:0];
  assign bi_next     = rdy_q & ~full;
  assign acc         = bo_we & bi_next;

  always_comb begin
    e_type   = type_q;
    e_w      = mcu_w_q;
    e_stride = stride_q;
    e_pix    = pix_q;
    e_x      = x_q;
    e_y      = y_q;
    e_base   = base_q;
    e_rowst  = rowst_q;
    e_roff   = roff_q;
    if (bo_begin) begin
      e_type   = bo_type;
      e_w      = cfg_mcu_w;
      e_stride = bo_type ? (ADDR_W'(cfg_mcu_w) << 4) : (ADDR_W'(cfg_mcu_w) << 3);
      e_pix    = '0;
      e_x      = '0;
      e_y      = '0;
      e_base   = '0;
      e_rowst  = '0;
      e_roff   = '0;
    end
  end

  always_comb begin
    dim        = e_type ? ADDR_W'(MCU_DIM_411) : ADDR_W'(MCU_DIM_444);
    col        = ADDR_W'(e_type ? {4'b0, e_pix[3:0]} : {5'b0, e_pix[2:0]});
    last_col   = e_type ? (e_pix[3:0] == 4'hF) : (e_pix[2:0] == 3'h7);
    last_pix   = e_type ? (e_pix == 8'(MCU_PIX_411 - 1)) : (e_pix == 8'(MCU_PIX_444 - 1));
    last_x     = (e_x == e_w - MCU_CNT_W'(1));
    dim_stride = e_type ? (e_stride << 4) : (e_stride << 3);
    addr       = e_base + e_roff + col;

    pix_n   = e_pix + 8'd1;
    roff_n  = e_roff;
    x_n     = e_x;
    y_n     = e_y;
    base_n  = e_base;
    rowst_n = e_rowst;
    if (last_pix) begin
      pix_n  = '0;
      roff_n = '0;
      if (last_x) begin
        x_n     = '0;
        y_n     = e_y + MCU_CNT_W'(1);
        rowst_n = e_rowst + dim_stride;
        base_n  = rowst_n;
      end else begin
        x_n    = e_x + MCU_CNT_W'(1);
        base_n = e_base + dim;
      end
    end else if (last_col) begin
      roff_n = e_roff + e_stride;
    end
  end

  // begin is resolved before end, so begin&end is a one-pixel (short) frame
  always_comb begin
    st_d   = st_q;
    take   = 1'b0;
    done_d = 1'b0;
    err_d  = 1'b0;
    if (acc) begin
      if (bo_begin) begin
        take  = 1'b1;
        st_d  = ST_RECV;
        err_d = (st_q == ST_RECV);
      end else if (st_q == ST_IDLE) begin
        err_d = 1'b1;
      end else begin
        take = 1'b1;
      end
      if (take && bo_end) begin
        done_d = 1'b1;
        st_d   = ST_IDLE;
        if (!last_pix || !last_x) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q       <= ST_IDLE;
      rdy_q      <= 1'b0;
      frame_done <= 1'b0;
      err_sync   <= 1'b0;
      type_q     <= 1'b0;
      mcu_w_q    <= '0;
      stride_q   <= '0;
      pix_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      base_q     <= '0;
      rowst_q    <= '0;
      roff_q     <= '0;
      s_vld      <= 1'b0;
      s_addr     <= '0;
      s_data     <= '0;
    end else begin
      st_q       <= st_d;
      rdy_q      <= 1'b1;
      frame_done <= done_d;
      err_sync   <= err_d;
      if (take) begin
        type_q   <= e_type;
        mcu_w_q  <= e_w;
        stride_q <= e_stride;
        pix_q    <= pix_n;
        x_q      <= x_n;
        y_q      <= y_n;
        base_q   <= base_n;
        rowst_q  <= rowst_n;
        roff_q   <= roff_n;
        s_vld    <= 1'b1;
        s_addr   <= addr;
        s_data   <= bo_data[31:8];
      end else if (push) begin
        s_vld <= 1'b0;
      end
    end
  end

  // ready only admits a beat when the FIFO has room, so the stage never overruns
  assign pop  = fb_we & fb_ready;
  assign push = s_vld & (~full | pop);

  jpeg_sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({s_addr, s_data}),
    .pop   (pop),
    .dout  (f_dout),
    .full  (full),
    .empty (empty)
  );

  assign fb_we   = ~empty;
  assign fb_addr = empty ? '0 : f_dout[FW-1:24];
  assign fb_data = empty ? '0 : f_dout[23:0];
endmodule

// File: tb/tb_jpeg_pix_rx.sv
// Directed bench for jpeg_pix_rx: address mapping, back-pressure, framing errors, reset.
module tb_jpeg_pix_rx;
  localparam int ADDR_W = 22;

  logic              clk = 1'b0;
  logic              rst;
  logic [12:0]       cfg_mcu_w;
  logic              bo_we, bo_begin, bo_end, bo_type;
  logic [31:0]       bo_data;
  logic              bi_next, fb_we, fb_ready, frame_done, err_sync;
  logic [ADDR_W-1:0] fb_addr;
  logic [23:0]       fb_data;

  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int wq_a[$];
  int wq_d[$];

  always #5 clk = ~clk;

  jpeg_pix_rx #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_mcu_w  (cfg_mcu_w),
    .bo_we      (bo_we),
    .bo_begin   (bo_begin),
    .bo_end     (bo_end),
    .bo_data    (bo_data),
    .bo_type    (bo_type),
    .bi_next    (bi_next),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_ready   (fb_ready),
    .frame_done (frame_done),
    .err_sync   (err_sync)
  );

  always @(negedge clk) begin
    if (fb_we && fb_ready) begin
      wq_a.push_back(int'(fb_addr));
      wq_d.push_back(int'(fb_data));
    end
    if (frame_done) done_cnt++;
    if (err_sync) err_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_addr(input bit t, input int w, input int k);
    int dim, np, m, p;
    dim = t ? 16 : 8;
    np  = dim * dim;
    m   = k / np;
    p   = k % np;
    return ((m / w) * dim + p / dim) * (w * dim) + (m % w) * dim + p % dim;
  endfunction

  function automatic int count_bad(input bit t, input int w, input bit chk_data);
    int bad = 0;
    for (int i = 0; i < wq_a.size(); i++) begin
      if (wq_a[i] != ref_addr(t, w, i)) bad++;
      if (chk_data && wq_d[i] != i) bad++;
    end
    return bad;
  endfunction

  task automatic clear();
    wq_a.delete();
    wq_d.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  task automatic idle();
    bo_we    = 1'b0;
    bo_begin = 1'b0;
    bo_end   = 1'b0;
  endtask

  // hold the beat until it transfers; returns just after the accepting edge
  task automatic send(input logic b, input logic e, input logic [31:0] d);
    bit ok;
    bo_we = 1'b1; bo_begin = b; bo_end = e; bo_data = d;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      ok = bi_next;
      @(posedge clk);
      #1;
      if (ok) return;
    end
    check("send_stall", bi_next, 1);
  endtask

  task automatic send_range(input int first, input int last, input bit bf, input bit el);
    for (int k = first; k < last; k++)
      send((k == first) && bf, (k == last - 1) && el, {k[23:0], 8'h00});
  endtask

  task automatic wait_writes(input string tag, input int n);
    for (int i = 0; i < 4000 && wq_a.size() < n; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check(tag, wq_a.size(), n);
  endtask

  initial begin
    int k, bad;
    bit stop;
    rst = 1'b0; cfg_mcu_w = '0; bo_type = 1'b0; bo_data = '0; fb_ready = 1'b1;
    idle();

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_bi_next", bi_next, 0);
    check("rst_fb_we", fb_we, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err_sync", err_sync, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_bi_next", bi_next, 1);
    @(posedge clk); #1;

    // 8x8, 2x1 MCUs
    clear(); bo_type = 1'b0; cfg_mcu_w = 13'd2;
    send_range(0, 128, 1, 1); idle();
    wait_writes("t1_count", 128);
    check("t1_mcu1_pix9", wq_a[73], 25);
    check("t1_last_addr", wq_a[127], 127);
    check("t1_map", count_bad(1'b0, 2, 1'b1), 0);
    check("t1_done", done_cnt, 1);
    check("t1_err", err_cnt, 0);

    // 4:2:0, 3x2 MCUs
    clear(); bo_type = 1'b1; cfg_mcu_w = 13'd3;
    send_range(0, 1536, 1, 1); idle();
    wait_writes("t2_count", 1536);
    check("t2_mcu01_first", wq_a[768], 768);
    check("t2_mcu21_last", wq_a[1535], 1535);
    begin
      bit seen [1536];
      bad = 0;
      foreach (wq_a[i]) begin
        if (wq_a[i] < 0 || wq_a[i] >= 1536 || seen[wq_a[i]]) bad++;
        else seen[wq_a[i]] = 1'b1;
      end
    end
    check("t2_permutation", bad, 0);
    check("t2_map", count_bad(1'b1, 3, 1'b1), 0);
    check("t2_done", done_cnt, 1);
    check("t2_err", err_cnt, 0);

    // back-pressure: 4 FIFO entries + 1 stage before ready drops
    clear(); bo_type = 1'b1; cfg_mcu_w = 13'd1; fb_ready = 1'b0;
    k = 0; stop = 1'b0;
    for (int c = 0; c < 20 && !stop; c++) begin
      bo_we = 1'b1; bo_begin = (k == 0); bo_end = 1'b0; bo_data = {k[23:0], 8'h00};
      @(negedge clk);
      if (!bi_next) stop = 1'b1;
      else begin
        @(posedge clk); #1;
        k++;
      end
    end
    idle();
    check("bp_accepted", k, 5);
    repeat (3) @(negedge clk);
    check("bp_hold_ready", bi_next, 0);
    check("bp_fb_we", fb_we, 1);
    @(posedge clk); #1 fb_ready = 1'b1;
    send_range(k, 256, 0, 1); idle();
    wait_writes("bp_count", 256);
    check("bp_order_map", count_bad(1'b1, 1, 1'b1), 0);
    check("bp_done", done_cnt, 1);
    check("bp_err", err_cnt, 0);

    // framing errors
    clear(); bo_type = 1'b0; cfg_mcu_w = 13'd2;
    send(1'b0, 1'b0, 32'hDEADBE00); idle();
    @(negedge clk);
    check("idle_drop_err", err_sync, 1);
    repeat (4) @(posedge clk); #1;
    check("idle_drop_nowrite", wq_a.size(), 0);
    send_range(0, 40, 1, 0);
    send(1'b1, 1'b0, 32'h0000_2800); idle();
    @(negedge clk);
    check("restart_err", err_sync, 1);
    @(posedge clk); #1;
    send_range(1, 11, 0, 1); idle();
    @(negedge clk);
    check("short_end_done", frame_done, 1);
    check("short_end_err", err_sync, 1);
    wait_writes("fr_count", 51);
    check("restart_addr0", wq_a[40], 0);
    check("restart_addr1", wq_a[41], 1);
    check("short_end_addr", wq_a[50], 18);
    check("fr_err_cnt", err_cnt, 3);
    check("fr_done_cnt", done_cnt, 1);

    // reset mid-frame with 3 FIFO entries
    bo_type = 1'b0; cfg_mcu_w = 13'd1; fb_ready = 1'b0;
    wq_a.delete(); wq_d.delete();
    send_range(0, 3, 1, 0); idle();
    repeat (3) @(negedge clk);
    check("mid_rst_fill", fb_we, 1);
    clear();
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("mid_rst_fb_we", fb_we, 0);
    check("mid_rst_fb_addr", fb_addr, 0);
    @(posedge clk); #1 fb_ready = 1'b1;
    send_range(0, 64, 1, 1); idle();
    wait_writes("mid_rst_count", 64);
    check("mid_rst_first", wq_a[0], 0);
    check("mid_rst_map", count_bad(1'b0, 1, 1'b1), 0);
    check("mid_rst_done", done_cnt, 1);
    check("mid_rst_err", err_cnt, 0);

    // single beat begin & end
    clear(); bo_type = 1'b0; cfg_mcu_w = 13'd1;
    send(1'b1, 1'b1, 32'h00ABCD00); idle();
    @(negedge clk);
    check("one_done", frame_done, 1);
    check("one_err", err_sync, 1);
    check("one_fb_we_n1", fb_we, 0);
    @(negedge clk);
    check("one_fb_we_n2", fb_we, 1);
    check("one_fb_addr", fb_addr, 0);
    check("one_fb_data", fb_data, 24'h00ABCD);
    check("one_done_clr", frame_done, 0);
    repeat (3) @(posedge clk); #1;
    check("one_count", wq_a.size(), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
